// File: rtl/i2c_master_seq.sv
// ---------------------------------------------------------------------------
// i2c_master_seq
//
// Command sequencer that sits in front of a byte-level i2c_master. The host
// queues single-byte write or read commands into a small FIFO. The sequencer
// hands them one at a time to the master and returns each read byte through
// a valid/ready response port.
//
// Parameters
//   FIFO_DEPTH      command FIFO depth in entries (power of two, 2..16)
//   TIMEOUT_CYCLES  clk cycles one transaction may spend in LAUNCH or XFER
//                   before it is aborted (timeout build only)
//
// Build option
//   I2C_SEQ_TIMEOUT_EN  when defined, a stuck transaction is aborted and the
//                       sticky err flag is set. When undefined, the sequencer
//                       waits on m_ready for as long as it takes and err is 0.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   cmd_valid/ready           host command handshake (ready = FIFO not full)
//   cmd_addr/rw/data          7-bit slave address, 0=write 1=read, write byte
//   rsp_valid/ready/data      read-byte response handshake
//   m_addr/m_rw/m_data_in     command fields presented to the i2c_master
//   m_enable                  start/hold request to the i2c_master
//   m_ready                   i2c_master idle indication
//   m_data_out                byte returned by the i2c_master on a read
//   busy                      sequencer is not idle
//   err                       sticky abort flag (0 unless the timeout is built)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_master_seq #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  // host command port
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  // host response port
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready,
  // i2c_master side
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_in,
  output logic       m_enable,
  input  logic       m_ready,
  input  logic [7:0] m_data_out,
  // status
  output logic       busy,
  output logic       err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_XFER,
    S_DONE,
    S_ABORT
  } state_t;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  cmd_t             head;

  assign cmd_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];

  // NOTE: the storage array has no reset; count and the pointers alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: cmd_addr, rw: cmd_rw, data: cmd_data};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: the pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   launch;
  logic   rsp_load;
  logic   tmo_abort;
  logic   tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    m_enable  = 1'b0;
    launch    = 1'b0;
    pop       = 1'b0;
    rsp_load  = 1'b0;
    tmo_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && m_ready) begin
          launch  = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Hold enable until the master acknowledges by going busy.
        m_enable = 1'b1;
        if (!m_ready) begin
          state_d = S_XFER;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          pop       = 1'b1;
          state_d   = S_ABORT;
        end
      end
      S_XFER: begin
        m_enable = 1'b1;
        if (m_ready) begin
          state_d = S_DONE;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          pop       = 1'b1;
          state_d   = S_ABORT;
        end
      end
      S_DONE: begin
        if (!m_rw) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else if (!rsp_valid || rsp_ready) begin
          // Response slot is free or being emptied this cycle.
          rsp_load = 1'b1;
          pop      = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_ABORT: begin
        // Wait for the master to drop its half-finished transfer.
        if (m_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // Master command fields: loaded only when a transaction is launched, so they
  // stay frozen for the whole time m_enable is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_data_in <= '0;
    end else if (launch) begin
      m_addr    <= head.addr;
      m_rw      <= head.rw;
      m_data_in <= head.data;
    end
  end

  // Response register: a new load wins over a consume in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (rsp_load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= m_data_out;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Transaction timeout
  // -------------------------------------------------------------------------
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts cycles spent in the current LAUNCH or XFER state; a state change
  // restarts it, so each phase gets the full allowance.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if ((state_d != state_q) || !(state_q inside {S_LAUNCH, S_XFER})) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           err <= 1'b0;
    else if (tmo_abort) err <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master_seq.sv
`timescale 1ns/1ps

module tb_i2c_master_seq;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TMO     = 16;
  localparam int WR_BUSY = 10;
`else
  localparam int TMO     = 4096;
  localparam int WR_BUSY = 20;
`endif

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
  } tx_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data_in;
  logic       m_enable;
  logic       m_ready;
  logic [7:0] m_data_out;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  // Reference model: commands in host order, what the slave actually saw,
  // read bytes the slave will return, and responses the host should get.
  tx_t        exp_cmd_q[$];
  tx_t        seen_q[$];
  logic [7:0] rdata_q[$];
  logic [7:0] exp_rsp_q[$];

  int   drop_dly = 3;
  int   busy_dly = 20;
  bit   rand_dly = 0;
  bit   stall    = 0;
  bit   hang     = 0;
  bit   rand_rsp = 0;
  bit   mon_en   = 0;
  logic rsp_ready_force = 1'b0;
  logic rsp_rand = 1'b0;

  assign rsp_ready = rand_rsp ? rsp_rand : rsp_ready_force;

  always #5 clk = ~clk;

  i2c_master_seq #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_rw     (cmd_rw),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .m_addr     (m_addr),
    .m_rw       (m_rw),
    .m_data_in  (m_data_in),
    .m_enable   (m_enable),
    .m_ready    (m_ready),
    .m_data_out (m_data_out),
    .busy       (busy),
    .err        (err)
  );

  // Behavioural i2c_master: idles with m_ready=1 (0 while stalled). On seeing
  // enable it records the command, drops ready after d_drop cycles, stays busy
  // d_busy cycles (longer while hang is set), then returns read data.
  initial begin : slave_bfm
    tx_t t;
    int  d_drop;
    int  d_busy;
    m_ready    = 1'b1;
    m_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (rst && m_enable && m_ready) begin
        t = '{addr: m_addr, rw: m_rw, data: m_data_in};
        seen_q.push_back(t);
        d_drop = rand_dly ? int'($urandom_range(0, 3)) : drop_dly;
        d_busy = rand_dly ? int'($urandom_range(1, 4)) : busy_dly;
        for (int i = 0; i < d_drop && rst; i++) begin
          @(posedge clk); #1;
        end
        m_ready = 1'b0;
        for (int i = 0; (i < d_busy || hang) && rst; i++) begin
          @(posedge clk); #1;
          if (m_enable) begin
            total++;
            if ({m_addr, m_rw, m_data_in} !== t) begin
              bad++;
              $display("FAIL m_stable got=%h exp=%h", {m_addr, m_rw, m_data_in}, t);
            end
          end
        end
        if (t.rw) m_data_out = (rdata_q.size() > 0) ? rdata_q.pop_front() : 8'($urandom);
        m_ready = 1'b1;
      end else begin
        m_ready = !stall;
      end
    end
  end

  // Randomised host response acceptance.
  initial begin : rsp_driver
    forever begin
      @(posedge clk); #1;
      rsp_rand = 1'($urandom_range(0, 1));
    end
  end

  // Response scoreboard: each consumed byte must be the next expected read.
  initial begin : rsp_monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst && rsp_valid && rsp_ready) begin
        total++;
        if (exp_rsp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_extra got=%h exp=none", rsp_data);
        end else begin
          e = exp_rsp_q.pop_front();
          if (rsp_data !== e) begin
            bad++;
            $display("FAIL rsp_data got=%h exp=%h", rsp_data, e);
          end
        end
      end
    end
  end

  // Offer one command and hold it until accepted (bounded); the model records
  // it at acceptance. rd is the byte the slave returns if it is a read.
  task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] d,
                          input logic [7:0] rd);
    bit acc;
    int n;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_data  = d;
    acc = 0;
    n   = 0;
    while (!acc && n < 500) begin
      acc = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout got=stuck exp=accepted addr=%h", a);
    end else begin
      exp_cmd_q.push_back('{addr: a, rw: rw, data: d});
      if (rw) begin
        rdata_q.push_back(rd);
        exp_rsp_q.push_back(rd);
      end
    end
  endtask

  task automatic wait_drained(output bit ok);
    ok = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!busy && m_ready && seen_q.size() == exp_cmd_q.size() && exp_rsp_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_model();
    exp_cmd_q.delete();
    seen_q.delete();
    rdata_q.delete();
    exp_rsp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, m_enable, busy, err, rsp_valid} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=10000", {cmd_ready, m_enable, busy, err, rsp_valid});
    end
    total++;
    if ({m_addr, m_rw, m_data_in, rsp_data} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {m_addr, m_rw, m_data_in, rsp_data});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, cmd_ready, m_enable} !== 3'b010) begin
      bad++;
      $display("FAIL reset_release got=%b exp=010", {busy, cmd_ready, m_enable});
    end
  endtask

  task automatic test_write();
    int hi;
    bit rv_seen;
    bit ok;
    rand_dly = 0;
    drop_dly = 3;
    busy_dly = WR_BUSY;
    push_cmd(7'h01, 1'b0, 8'hCD, 8'h00);
    total++;
    if (m_enable !== 1'b0) begin
      bad++;
      $display("FAIL wr_latency_early got=%b exp=0", m_enable);
    end
    @(posedge clk); #1;
    total++;
    if (m_enable !== 1'b1) begin
      bad++;
      $display("FAIL wr_latency got=%b exp=1", m_enable);
    end
    total++;
    if ({m_addr, m_rw, m_data_in} !== {7'h01, 1'b0, 8'hCD}) begin
      bad++;
      $display("FAIL wr_fields got=%h exp=%h", {m_addr, m_rw, m_data_in}, {7'h01, 1'b0, 8'hCD});
    end
    hi = 1;
    rv_seen = 0;
    while (m_enable && hi < 300) begin
      @(posedge clk); #1;
      if (m_enable) hi++;
      rv_seen |= rsp_valid;
    end
    total++;
    if (hi != drop_dly + busy_dly + 1) begin
      bad++;
      $display("FAIL wr_enable_len got=%0d exp=%0d", hi, drop_dly + busy_dly + 1);
    end
    total++;
    if ({busy, m_addr, m_data_in} !== {1'b1, 7'h01, 8'hCD}) begin
      bad++;
      $display("FAIL wr_done got=%h exp=%h", {busy, m_addr, m_data_in}, {1'b1, 7'h01, 8'hCD});
    end
    @(posedge clk); #1;
    rv_seen |= rsp_valid;
    total++;
    if (busy !== 1'b0 || rv_seen) begin
      bad++;
      $display("FAIL wr_finish got=busy%b rsp%b exp=busy0 rsp0", busy, rv_seen);
    end
    wait_drained(ok);
    total++;
    if (!ok || seen_q.size() != 1) begin
      bad++;
      $display("FAIL wr_drain got=%0d exp=1", seen_q.size());
    end
    clear_model();
  endtask

  task automatic test_read_backpressure();
    int n;
    bit ok;
    mon_en = 0;
    rsp_ready_force = 1'b0;
    drop_dly = 3;
    busy_dly = 5;
    push_cmd(7'h01, 1'b1, 8'h00, 8'h55);
    push_cmd(7'h01, 1'b1, 8'h00, 8'hF0);
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h55) begin
      bad++;
      $display("FAIL rd_first got=%b/%h exp=1/55", rsp_valid, rsp_data);
    end
    n = 0;
    while (seen_q.size() < 2 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    while (m_enable && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, m_enable, rsp_valid, rsp_data} !== {1'b1, 1'b0, 1'b1, 8'h55}) begin
      bad++;
      $display("FAIL rd_hold got=%h exp=%h", {busy, m_enable, rsp_valid, rsp_data},
               {1'b1, 1'b0, 1'b1, 8'h55});
    end
    rsp_ready_force = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, rsp_data, busy} !== {1'b1, 8'hF0, 1'b0}) begin
      bad++;
      $display("FAIL rd_second got=%h exp=%h", {rsp_valid, rsp_data, busy}, {1'b1, 8'hF0, 1'b0});
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_consume got=%b exp=0", rsp_valid);
    end
    rsp_ready_force = 1'b0;
    exp_rsp_q.delete();
    wait_drained(ok);
    total++;
    if (!ok || seen_q.size() != 2) begin
      bad++;
      $display("FAIL rd_drain got=%0d exp=2", seen_q.size());
    end
    clear_model();
  endtask

  task automatic test_full_fifo();
    int  ready_seen;
    bit  acc;
    int  n;
    bit  ok;
    tx_t c5;
    drop_dly = 1;
    busy_dly = 2;
    stall = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      push_cmd(7'($urandom), 1'b0, 8'($urandom), 8'h00);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%b exp=0", cmd_ready);
    end
    c5 = '{addr: 7'($urandom), rw: 1'b0, data: 8'($urandom)};
    cmd_valid = 1'b1;
    cmd_addr  = c5.addr;
    cmd_rw    = c5.rw;
    cmd_data  = c5.data;
    ready_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (cmd_ready) ready_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (ready_seen != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_blocked got=ready%0d busy%b exp=ready0 busy0", ready_seen, busy);
    end
    stall = 0;
    acc = 0;
    n = 0;
    while (!acc && n < 300) begin
      acc = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL full_fifth got=stuck exp=accepted");
    end else begin
      exp_cmd_q.push_back(c5);
    end
    wait_drained(ok);
    total++;
    if (!ok || seen_q.size() != exp_cmd_q.size()) begin
      bad++;
      $display("FAIL full_count got=%0d exp=%0d", seen_q.size(), exp_cmd_q.size());
    end
    for (int i = 0; i < exp_cmd_q.size() && i < seen_q.size(); i++) begin
      total++;
      if (seen_q[i] !== exp_cmd_q[i]) begin
        bad++;
        $display("FAIL full_order[%0d] got=%h exp=%h", i, seen_q[i], exp_cmd_q[i]);
      end
    end
    clear_model();
  endtask

  task automatic test_random();
    bit ok;
    rand_dly = 1;
    rand_rsp = 1;
    mon_en   = 1;
    for (int k = 0; k < 40; k++) begin
      push_cmd(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    wait_drained(ok);
    total++;
    if (!ok || seen_q.size() != exp_cmd_q.size()) begin
      bad++;
      $display("FAIL rand_drain got=%0d/%0d exp=%0d/0", seen_q.size(), exp_rsp_q.size(),
               exp_cmd_q.size());
    end
    for (int i = 0; i < exp_cmd_q.size() && i < seen_q.size(); i++) begin
      total++;
      if (seen_q[i].addr !== exp_cmd_q[i].addr || seen_q[i].rw !== exp_cmd_q[i].rw ||
          (!exp_cmd_q[i].rw && seen_q[i].data !== exp_cmd_q[i].data)) begin
        bad++;
        $display("FAIL rand_order[%0d] got=%h exp=%h", i, seen_q[i], exp_cmd_q[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rand_rsp_left got=%b exp=0", rsp_valid);
    end
    rand_dly = 0;
    rand_rsp = 0;
    mon_en   = 0;
    clear_model();
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    int viol;
    drop_dly = 2;
    busy_dly = 20;
    push_cmd(7'h2A, 1'b1, 8'h00, 8'h99);
    push_cmd(7'h15, 1'b0, 8'h3C, 8'h00);
    n = 0;
    while (!(m_enable && !m_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    total++;
    if ({m_enable, busy, cmd_ready} !== 3'b001) begin
      bad++;
      $display("FAIL rstmid_async got=%b exp=001", {m_enable, busy, cmd_ready});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid !== 1'b0 || m_enable !== 1'b0 || busy !== 1'b0) viol++;
      @(posedge clk); #1;
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL rstmid_quiet got=%0d exp=0", viol);
    end
    clear_model();
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    bit rv_seen;
    bit ok;
    drop_dly = 1;
    busy_dly = 2;
    hang = 1;
    push_cmd(7'h11, 1'b0, 8'hA1, 8'h00);
    push_cmd(7'h22, 1'b0, 8'hB2, 8'h00);
    @(posedge clk); #1;
    hi = m_enable ? 1 : 0;
    rv_seen = 0;
    while (m_enable && hi < 300) begin
      @(posedge clk); #1;
      if (m_enable) hi++;
    end
    total++;
    if (hi != drop_dly + 1 + TMO) begin
      bad++;
      $display("FAIL tmo_len got=%0d exp=%0d", hi, drop_dly + 1 + TMO);
    end
    total++;
    if ({err, busy, m_enable} !== 3'b110) begin
      bad++;
      $display("FAIL tmo_abort got=%b exp=110", {err, busy, m_enable});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || seen_q.size() != 1) begin
      bad++;
      $display("FAIL tmo_wait got=%b/%0d exp=1/1", busy, seen_q.size());
    end
    hang = 0;
    for (int i = 0; i < 60; i++) begin
      rv_seen |= rsp_valid;
      @(posedge clk); #1;
    end
    wait_drained(ok);
    total++;
    if (!ok || seen_q.size() != 2 || seen_q[1] !== exp_cmd_q[1] || rv_seen || err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_next got=%0d err%b rsp%b exp=2 err1 rsp0", seen_q.size(), err, rv_seen);
    end
    rst = 1'b0;
    #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_err_clear got=%b exp=0", err);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_model();
  endtask
`endif

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_rw    = 1'b0;
    cmd_data  = '0;
    test_reset();
    test_write();
    test_read_backpressure();
    test_full_fifo();
    test_random();
    test_reset_mid_xfer();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
